// File: rtl/cla_chk_pkg.sv
// Shared definitions for the 13-bit CLA batch checker: widths, FSM states,
// LFSR tap mask and the fixed corner-vector table.
package cla_chk_pkg;

  localparam int OPW        = 13;
  localparam int SUMW       = OPW + 1;
  localparam int LFSR_W     = 26;
  localparam int CORNER_CNT = 4;

  // x^26 + x^6 + x^2 + x + 1 -> feedback from state bits 25, 5, 1, 0
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 26'h2000023;

  // Low 26 bits of 0x1ACE5EED
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 26'h2CE5EED;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } operands_t;

  // Fixed corners that exercise zero, full carry chain, single-carry ripple
  // and alternating propagate patterns before the pseudo-random vectors.
  function automatic operands_t corner_vec(input logic [1:0] sel);
    operands_t v;
    case (sel)
      2'd0:    v = '{a: 13'h0000, b: 13'h0000};
      2'd1:    v = '{a: 13'h1FFF, b: 13'h1FFF};
      2'd2:    v = '{a: 13'h1FFF, b: 13'h0001};
      default: v = '{a: 13'h0AAA, b: 13'h1555};
    endcase
    return v;
  endfunction

  function automatic logic [SUMW-1:0] expected_sum(input logic [OPW-1:0] a,
                                                   input logic [OPW-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/lfsr26.sv
// 26-bit Fibonacci LFSR with synchronous seed reload and single-step advance.
module lfsr26
  import cla_chk_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_reg;
  logic              feedback;

  assign feedback = ^(state_reg & LFSR_TAPS);
  assign state    = state_reg;

  // Reload wins over advance so a new batch always restarts the sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SEED;
    end else if (load) begin
      state_reg <= SEED;
    end else if (advance) begin
      state_reg <= {state_reg[LFSR_W-2:0], feedback};
    end
  end

endmodule

// File: rtl/cla13_batch_checker.sv
// Drives a batch of operand pairs into an external 13-bit CLA and counts
// matching / mismatching sums, latching the index of the first mismatch.
module cla13_batch_checker
  import cla_chk_pkg::*;
#(
  parameter int                NUM_VECTORS = 256,
  parameter logic [LFSR_W-1:0] SEED        = DEFAULT_SEED
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  output logic [OPW-1:0]  o_add1,
  output logic [OPW-1:0]  o_add2,
  input  logic [SUMW-1:0] i_result,
  output logic            o_busy,
  output logic            o_done,
  output logic [15:0]     o_pass_cnt,
  output logic [15:0]     o_fail_cnt,
  output logic [15:0]     o_first_fail_idx,
  output logic            o_first_fail_valid
);

  localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] CORNER_LAST = 16'(CORNER_CNT);

  state_t            state_reg, state_next;
  logic              start_batch, check_en, load_next, lfsr_adv;
  logic [LFSR_W-1:0] lfsr_state;
  operands_t         next_vec;

  logic [15:0]       idx_reg;       // index of the next vector to load
  logic [OPW-1:0]    add1_reg, add2_reg;
  logic [SUMW-1:0]   exp_reg;
  logic [15:0]       pass_reg, fail_reg, ff_idx_reg;
  logic              ff_valid_reg;

  lfsr26 #(.SEED(SEED)) u_lfsr (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .load    (start_batch),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state and per-edge control strobes.
  always_comb begin
    state_next  = state_reg;
    start_batch = 1'b0;
    check_en    = 1'b0;
    load_next   = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          start_batch = 1'b1;
          state_next  = ST_RUN;
        end
      end
      ST_RUN: begin
        check_en  = 1'b1;
        load_next = 1'b1;
        if (idx_reg == LAST_IDX) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        check_en   = 1'b1;
        state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand source: corner table for the first vectors, LFSR afterwards.
  always_comb begin
    next_vec = corner_vec(idx_reg[1:0]);
    if (idx_reg >= CORNER_LAST) begin
      next_vec.a = lfsr_state[OPW-1:0];
      next_vec.b = lfsr_state[LFSR_W-1:OPW];
    end
  end

  assign lfsr_adv = load_next && (idx_reg >= CORNER_LAST);

  // Operand/expected pipeline, result counters and first-mismatch capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_reg      <= '0;
      add1_reg     <= '0;
      add2_reg     <= '0;
      exp_reg      <= '0;
      pass_reg     <= '0;
      fail_reg     <= '0;
      ff_idx_reg   <= '0;
      ff_valid_reg <= 1'b0;
    end else if (start_batch) begin
      idx_reg      <= 16'd1;
      add1_reg     <= corner_vec(2'd0).a;
      add2_reg     <= corner_vec(2'd0).b;
      exp_reg      <= expected_sum(corner_vec(2'd0).a, corner_vec(2'd0).b);
      pass_reg     <= '0;
      fail_reg     <= '0;
      ff_idx_reg   <= '0;
      ff_valid_reg <= 1'b0;
    end else begin
      if (check_en) begin
        if (i_result == exp_reg) begin
          pass_reg <= pass_reg + 16'd1;
        end else begin
          fail_reg <= fail_reg + 16'd1;
          if (!ff_valid_reg) begin
            // The vector on the operands is always one behind idx_reg.
            ff_idx_reg   <= idx_reg - 16'd1;
            ff_valid_reg <= 1'b1;
          end
        end
      end
      if (load_next) begin
        add1_reg <= next_vec.a;
        add2_reg <= next_vec.b;
        exp_reg  <= expected_sum(next_vec.a, next_vec.b);
        idx_reg  <= idx_reg + 16'd1;
      end
    end
  end

  assign o_add1             = add1_reg;
  assign o_add2             = add2_reg;
  assign o_busy             = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign o_done             = (state_reg == ST_DONE);
  assign o_pass_cnt         = pass_reg;
  assign o_fail_cnt         = fail_reg;
  assign o_first_fail_idx   = ff_idx_reg;
  assign o_first_fail_valid = ff_valid_reg;

endmodule

// File: tb/tb_cla13_batch_checker.sv
// Self-checking bench: three checker instances (N=8 with a configurable faulty
// CLA, N=4 with sum bit 13 stuck low, N=65535 with a correct CLA).
module tb_cla13_batch_checker;

  localparam int N8   = 8;
  localparam int N4   = 4;
  localparam int NBIG = 65535;

  localparam logic [31:0] SEED_WORD = 32'h1ACE5EED;
  localparam logic [25:0] TB_SEED   = SEED_WORD[25:0];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // ---- N=8 instance with configurable stuck-at faults on the CLA output
  logic        start8 = 1'b0;
  logic [12:0] a8, b8;
  logic [13:0] r8;
  logic        busy8, done8, ffv8;
  logic [15:0] pass8, fail8, ffi8;
  logic [13:0] and_mask8 = 14'h3FFF;
  logic [13:0] or_mask8  = 14'h0000;
  assign r8 = (({1'b0, a8} + {1'b0, b8}) & and_mask8) | or_mask8;

  cla13_batch_checker #(.NUM_VECTORS(N8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8),
    .o_add1(a8), .o_add2(b8), .i_result(r8),
    .o_busy(busy8), .o_done(done8),
    .o_pass_cnt(pass8), .o_fail_cnt(fail8),
    .o_first_fail_idx(ffi8), .o_first_fail_valid(ffv8)
  );

  // ---- N=4 instance, CLA with sum bit 13 stuck at 0
  logic        start4 = 1'b0;
  logic [12:0] a4, b4;
  logic [13:0] r4;
  logic        busy4, done4, ffv4;
  logic [15:0] pass4, fail4, ffi4;
  assign r4 = ({1'b0, a4} + {1'b0, b4}) & 14'h1FFF;

  cla13_batch_checker #(.NUM_VECTORS(N4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start4),
    .o_add1(a4), .o_add2(b4), .i_result(r4),
    .o_busy(busy4), .o_done(done4),
    .o_pass_cnt(pass4), .o_fail_cnt(fail4),
    .o_first_fail_idx(ffi4), .o_first_fail_valid(ffv4)
  );

  // ---- maximum-size instance, correct CLA
  logic        startb = 1'b0;
  logic [12:0] ab, bb;
  logic [13:0] rb;
  logic        busyb, doneb, ffvb;
  logic [15:0] passb, failb, ffib;
  assign rb = {1'b0, ab} + {1'b0, bb};

  cla13_batch_checker #(.NUM_VECTORS(NBIG)) u_dutb (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(startb),
    .o_add1(ab), .o_add2(bb), .i_result(rb),
    .o_busy(busyb), .o_done(doneb),
    .o_pass_cnt(passb), .o_fail_cnt(failb),
    .o_first_fail_idx(ffib), .o_first_fail_valid(ffvb)
  );

  // Reference vector list for the N=8 batch
  logic [12:0] va[N8];
  logic [12:0] vb[N8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] lfsr_step(input logic [25:0] s);
    return {s[24:0], s[25] ^ s[5] ^ s[1] ^ s[0]};
  endfunction

  task automatic build_vectors();
    logic [25:0] s;
    va[0] = 13'h0000; vb[0] = 13'h0000;
    va[1] = 13'h1FFF; vb[1] = 13'h1FFF;
    va[2] = 13'h1FFF; vb[2] = 13'h0001;
    va[3] = 13'h0AAA; vb[3] = 13'h1555;
    s = TB_SEED;
    for (int k = 4; k < N8; k++) begin
      va[k] = s[12:0];
      vb[k] = s[25:13];
      s = lfsr_step(s);
    end
  endtask

  // One full N=8 batch with the given CLA fault; optionally keeps start high
  // through RUN to show it is ignored there.
  task automatic run8(input logic [13:0] am, input logic [13:0] om, input bit hold);
    int          exp_pass = 0;
    int          exp_fail = 0;
    int          exp_ffi  = 0;
    bit          exp_ffv  = 0;
    logic [13:0] sum, res;
    and_mask8 = am;
    or_mask8  = om;
    for (int k = 0; k < N8; k++) begin
      sum = {1'b0, va[k]} + {1'b0, vb[k]};
      res = (sum & am) | om;
      if (res == sum) exp_pass++;
      else begin
        exp_fail++;
        if (!exp_ffv) begin exp_ffv = 1; exp_ffi = k; end
      end
    end
    @(negedge clk); start8 = 1'b1;
    @(posedge clk);
    @(negedge clk); if (!hold) start8 = 1'b0;
    check("start_pass_clr", pass8, 0);
    check("start_fail_clr", fail8, 0);
    check("start_ffv_clr", ffv8, 0);
    check("start_busy", busy8, 1);
    check("vec0_a", a8, va[0]);
    check("vec0_b", b8, vb[0]);
    for (int k = 1; k < N8; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == N8 - 1) start8 = 1'b0;
      check($sformatf("vec%0d_a", k), a8, va[k]);
      check($sformatf("vec%0d_b", k), b8, vb[k]);
      check($sformatf("busy_e%0d", k), busy8, 1);
      check($sformatf("done_e%0d", k), done8, 0);
    end
    @(posedge clk); @(negedge clk);
    check("done_at_eN", done8, 1);
    check("busy_at_eN", busy8, 0);
    check("pass_cnt", pass8, exp_pass);
    check("fail_cnt", fail8, exp_fail);
    check("ff_valid", ffv8, exp_ffv);
    check("ff_idx", ffi8, exp_ffi);
    $display("[TB] batch8 and=%h or=%h hold=%0d pass=%0d fail=%0d ffv=%0d ffi=%0d",
             am, om, hold, pass8, fail8, ffv8, ffi8);
    repeat (3) @(negedge clk);
    check("done_hold_pass", pass8, exp_pass);
    check("done_hold_fail", fail8, exp_fail);
    check("done_hold_a", a8, va[N8-1]);
    check("done_hold_state", done8, 1);
  endtask

  initial begin
    int bit_i;
    int edges;
    build_vectors();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_add1", a8, 0);
    check("rst_add2", b8, 0);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_pass", pass8, 0);
    check("rst_fail", fail8, 0);
    check("rst_ffi", ffi8, 0);
    check("rst_ffv", ffv8, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start", busy8, 0);

    // Correct CLA, then randomized stuck-at faults
    run8(14'h3FFF, 14'h0000, 1'b0);
    for (int t = 0; t < 4; t++) begin
      bit_i = $urandom_range(0, 13);
      if ($urandom_range(0, 1) == 1) run8(~(14'd1 << bit_i), 14'h0000, 1'b0);
      else                           run8(14'h3FFF, 14'd1 << bit_i, 1'b0);
    end

    // Start held through RUN, then re-pulsed in DONE: identical replay
    run8(14'h3FFF, 14'h0000, 1'b1);
    run8(14'h3FFF, 14'h0000, 1'b0);

    // Asynchronous reset three edges into RUN
    @(negedge clk); start8 = 1'b1;
    @(posedge clk);
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy8, 0);
    check("arst_done", done8, 0);
    check("arst_add1", a8, 0);
    check("arst_add2", b8, 0);
    check("arst_pass", pass8, 0);
    check("arst_ffv", ffv8, 0);
    $display("[TB] async reset mid-run busy=%0d add1=%h pass=%0d", busy8, a8, pass8);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle_busy", busy8, 0);
    check("post_rst_idle_done", done8, 0);
    check("post_rst_idle_a", a8, 0);
    run8(14'h3FFF, 14'h0000, 1'b0);

    // N=4 with sum bit 13 stuck at 0
    @(negedge clk); start4 = 1'b1;
    @(posedge clk);
    @(negedge clk); start4 = 1'b0;
    check("n4_corner0_a", a4, 13'h0000);
    check("n4_corner0_b", b4, 13'h0000);
    @(posedge clk); @(negedge clk);
    check("n4_corner1_a", a4, 13'h1FFF);
    check("n4_corner1_b", b4, 13'h1FFF);
    edges = 1;
    while (!done4 && edges < 20) begin
      @(posedge clk); @(negedge clk);
      edges++;
    end
    check("n4_done_latency", edges, N4);
    check("n4_pass", pass4, 2);
    check("n4_fail", fail4, 2);
    check("n4_ffi", ffi4, 1);
    check("n4_ffv", ffv4, 1);
    $display("[TB] batch4 pass=%0d fail=%0d ffi=%0d ffv=%0d", pass4, fail4, ffi4, ffv4);

    // Maximum batch size
    @(negedge clk); startb = 1'b1;
    @(posedge clk);
    @(negedge clk); startb = 1'b0;
    edges = 0;
    while (!doneb && edges < 70000) begin
      @(posedge clk); @(negedge clk);
      edges++;
    end
    check("big_done_latency", edges, NBIG);
    check("big_pass", passb, 16'hFFFF);
    check("big_fail", failb, 0);
    check("big_ffv", ffvb, 0);
    $display("[TB] batch65535 pass=%0h fail=%0h ffv=%0d", passb, failb, ffvb);
    repeat (2) @(negedge clk);
    check("big_hold_pass", passb, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
